boreal_weight_sweeper: RTL and testbench

Sequencer that drives the synaptic-weight BRAM read port and the `boreal_learning` update block. It walks the weight array once per sweep, pairing each address with one (ε, μ) sample from an upstream stream. It issues the Port A read and presents ε/μ to the learning block aligned with the returning `w_old`. It also generates the Port B write address aligned with the learning block's `we_b`/`w_new`.

---
 rtl/boreal_weight_sweeper.sv | 197 +++++++++++++++++++
 tb/tb_boreal_weight_sweeper.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_weight_sweeper.sv
// rtl/boreal_weight_sweeper.sv - weight-array sweep sequencer for BRAM port A/B and boreal_learning
// Define BOREAL_SWEEP_STATS_EN to build the stall/update statistics counters.
module boreal_weight_sweeper #(
  parameter int NUM_SYN = 1024,
  parameter int ADDR_W  = 10,
  parameter int RD_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                learn_en,
  input  logic                abort,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [15:0]  s_eps,
  input  logic signed [15:0]  s_mu,
  output logic [ADDR_W-1:0]   addr_a,
  output logic                en_a,
  output logic signed [15:0]  epsilon,
  output logic signed [15:0]  mu,
  output logic                enable_learning,
  output logic [ADDR_W-1:0]   addr_b,
  output logic                busy,
  output logic                done,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         upd_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SYN - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               lrn_q, lrn_d;
  logic [2:0]         dcnt_q, dcnt_d;
  logic               done_q, done_d;
  logic               xfer;

  // Delay line: stage k carries the slot whose transfer happened k cycles ago.
  logic [RD_LAT:1]    sv_q, sv_d;
  logic [RD_LAT:1]    wl_q, wl_d;
  logic [ADDR_W-1:0]  adr_q [1:RD_LAT];
  logic [ADDR_W-1:0]  adr_d [1:RD_LAT];
  logic signed [15:0] eps_q [1:RD_LAT];
  logic signed [15:0] eps_d [1:RD_LAT];
  logic signed [15:0] mu_q  [1:RD_LAT];
  logic signed [15:0] mu_d  [1:RD_LAT];
  logic [ADDR_W-1:0]  addr_b_q, addr_b_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lrn_d   = lrn_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    s_ready = (state_q == ST_RUN) && !abort;
    xfer    = s_valid && s_ready;
    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          state_d = ST_RUN;
          idx_d   = '0;
          lrn_d   = learn_en;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Hold long enough for the last issued slot to reach the write port.
        if (dcnt_q == DRAIN_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sv_d       = sv_q;
    wl_d       = wl_q;
    adr_d      = adr_q;
    eps_d      = eps_q;
    mu_d       = mu_q;
    sv_d[1]    = xfer;
    wl_d[1]    = xfer && lrn_q;
    adr_d[1]   = xfer ? idx_q : adr_q[1];
    eps_d[1]   = xfer ? s_eps : eps_q[1];
    mu_d[1]    = xfer ? s_mu  : mu_q[1];
    for (int k = 2; k <= RD_LAT; k++) begin
      sv_d[k]  = sv_q[k-1];
      wl_d[k]  = wl_q[k-1];
      adr_d[k] = adr_q[k-1];
      eps_d[k] = eps_q[k-1];
      mu_d[k]  = mu_q[k-1];
    end
    addr_b_d = sv_q[RD_LAT] ? adr_q[RD_LAT] : addr_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      lrn_q    <= 1'b0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
      sv_q     <= '0;
      wl_q     <= '0;
      addr_b_q <= '0;
      for (int k = 1; k <= RD_LAT; k++) begin
        adr_q[k] <= '0;
        eps_q[k] <= '0;
        mu_q[k]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lrn_q    <= lrn_d;
      dcnt_q   <= dcnt_d;
      done_q   <= done_d;
      sv_q     <= sv_d;
      wl_q     <= wl_d;
      addr_b_q <= addr_b_d;
      adr_q    <= adr_d;
      eps_q    <= eps_d;
      mu_q     <= mu_d;
    end
  end

  assign addr_a          = adr_q[1];
  assign en_a            = sv_q[1];
  assign epsilon         = eps_q[RD_LAT];
  assign mu              = mu_q[RD_LAT];
  assign enable_learning = wl_q[RD_LAT];
  assign addr_b          = addr_b_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;

`ifdef BOREAL_SWEEP_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] upd_q, upd_d;
  logic        start_acc;

  always_comb begin
    stall_d   = stall_q;
    upd_d     = upd_q;
    start_acc = (state_q == ST_IDLE) && start && !done_q;
    if (start_acc) begin
      stall_d = '0;
      upd_d   = '0;
    end else begin
      if ((state_q == ST_RUN) && !s_valid && (stall_q != 16'hFFFF)) begin
        stall_d = stall_q + 16'd1;
      end
      if (wl_q[RD_LAT] && (upd_q != 16'hFFFF)) begin
        upd_d = upd_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      upd_q   <= '0;
    end else begin
      stall_q <= stall_d;
      upd_q   <= upd_d;
    end
  end

  assign stall_cnt = stall_q;
  assign upd_cnt   = upd_q;
`else
  assign stall_cnt = '0;
  assign upd_cnt   = '0;
`endif

endmodule

// File: tb/tb_boreal_weight_sweeper.sv
// tb/tb_boreal_weight_sweeper.sv - randomized bench for boreal_weight_sweeper at RD_LAT 1 and 3
module tb_boreal_weight_sweeper;
  localparam int NSYN = 8;
  localparam int AW   = 3;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        learn_en = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_eps = '0;
  logic [15:0] s_mu = '0;

  logic [1:0]    s_ready_o, en_a_o, el_o, busy_o, done_o;
  logic [AW-1:0] addr_a_o [2];
  logic [AW-1:0] addr_b_o [2];
  logic [15:0]   eps_o [2];
  logic [15:0]   mu_o [2];
  logic [15:0]   stall_o [2];
  logic [15:0]   upd_o [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    boreal_weight_sweeper #(.NUM_SYN(NSYN), .ADDR_W(AW), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .learn_en(learn_en), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready_o[g]), .s_eps(s_eps), .s_mu(s_mu),
      .addr_a(addr_a_o[g]), .en_a(en_a_o[g]), .epsilon(eps_o[g]), .mu(mu_o[g]),
      .enable_learning(el_o[g]), .addr_b(addr_b_o[g]), .busy(busy_o[g]), .done(done_o[g]),
      .stall_cnt(stall_o[g]), .upd_cnt(upd_o[g])
    );
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int barrier = 0;

  // Reference model: sweep phase per unit plus a per-cycle log of accepted samples.
  int  m_st [2];
  int  m_idx [2];
  int  m_drain [2];
  bit  m_lrn [2];
  bit  m_done [2];
  int  m_ab [2];
  int  m_stall [2];
  int  m_upd [2];
  bit          x_vld [2][MAXC];
  bit          x_lrn [2][MAXC];
  int          x_idx [2][MAXC];
  logic [15:0] x_eps [2][MAXC];
  logic [15:0] x_mu  [2][MAXC];
  int  n_xfer;
  int  obs_el [2];
  int  first_x [2];
  int  done_at [2];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic bit hv(input int u, input int c);
    if (c < barrier || c < 0 || c >= MAXC) return 1'b0;
    return x_vld[u][c];
  endfunction

  function automatic bit hl(input int u, input int c);
    if (!hv(u, c)) return 1'b0;
    return x_lrn[u][c];
  endfunction

  task automatic expect_reset_outputs(input int u);
    expect_eq($sformatf("rst_s_ready%0d", u), s_ready_o[u], 0);
    expect_eq($sformatf("rst_en_a%0d", u), en_a_o[u], 0);
    expect_eq($sformatf("rst_enable_learning%0d", u), el_o[u], 0);
    expect_eq($sformatf("rst_busy%0d", u), busy_o[u], 0);
    expect_eq($sformatf("rst_done%0d", u), done_o[u], 0);
    expect_eq($sformatf("rst_addr_a%0d", u), addr_a_o[u], 0);
    expect_eq($sformatf("rst_addr_b%0d", u), addr_b_o[u], 0);
    expect_eq($sformatf("rst_epsilon%0d", u), eps_o[u], 0);
    expect_eq($sformatf("rst_mu%0d", u), mu_o[u], 0);
    expect_eq($sformatf("rst_stall_cnt%0d", u), stall_o[u], 0);
    expect_eq($sformatf("rst_upd_cnt%0d", u), upd_o[u], 0);
  endtask

  task automatic sample_and_step();
    for (int u = 0; u < 2; u++) begin
      int L;
      bit e_rdy, e_el, xf, nd;
      L = lat(u);
      if (!rst_n) begin
        expect_reset_outputs(u);
        m_st[u] = 0; m_done[u] = 1'b0; m_ab[u] = 0; m_stall[u] = 0; m_upd[u] = 0;
        barrier = cyc + 1;
        continue;
      end
      e_rdy = (m_st[u] == 1) && !abort;
      e_el  = hl(u, cyc - L);
      if (hv(u, cyc - L - 1)) m_ab[u] = x_idx[u][cyc-L-1];
      expect_eq($sformatf("s_ready%0d", u), s_ready_o[u], e_rdy);
      expect_eq($sformatf("en_a%0d", u), en_a_o[u], hv(u, cyc - 1));
      if (hv(u, cyc - 1)) expect_eq($sformatf("addr_a%0d", u), addr_a_o[u], x_idx[u][cyc-1]);
      expect_eq($sformatf("enable_learning%0d", u), el_o[u], e_el);
      if (hv(u, cyc - L)) begin
        expect_eq($sformatf("epsilon%0d", u), eps_o[u], x_eps[u][cyc-L]);
        expect_eq($sformatf("mu%0d", u), mu_o[u], x_mu[u][cyc-L]);
      end
      expect_eq($sformatf("addr_b%0d", u), addr_b_o[u], m_ab[u]);
      expect_eq($sformatf("busy%0d", u), busy_o[u], m_st[u] != 0);
      expect_eq($sformatf("done%0d", u), done_o[u], m_done[u]);
`ifdef BOREAL_SWEEP_STATS_EN
      expect_eq($sformatf("stall_cnt%0d", u), stall_o[u], m_stall[u]);
      expect_eq($sformatf("upd_cnt%0d", u), upd_o[u], m_upd[u]);
`else
      expect_eq($sformatf("stall_cnt%0d", u), stall_o[u], 0);
      expect_eq($sformatf("upd_cnt%0d", u), upd_o[u], 0);
`endif
      obs_el[u] += int'(el_o[u]);
      if (done_o[u]) done_at[u] = cyc;

      xf = e_rdy && s_valid;
      if (cyc < MAXC) begin
        x_vld[u][cyc] = xf; x_idx[u][cyc] = m_idx[u]; x_lrn[u][cyc] = m_lrn[u];
        x_eps[u][cyc] = s_eps; x_mu[u][cyc] = s_mu;
      end
      if (xf && first_x[u] < 0) first_x[u] = cyc;
      if (m_st[u] == 0 && start && !m_done[u]) begin
        m_stall[u] = 0; m_upd[u] = 0;
      end else begin
        if (m_st[u] == 1 && !s_valid && m_stall[u] < 65535) m_stall[u]++;
        if (e_el && m_upd[u] < 65535) m_upd[u]++;
      end
      nd = 1'b0;
      case (m_st[u])
        0: if (start && !m_done[u]) begin m_st[u] = 1; m_idx[u] = 0; m_lrn[u] = learn_en; end
        1: begin
          if (abort) begin
            m_st[u] = 2; m_drain[u] = L + 1;
          end else if (xf) begin
            if (u == 0) n_xfer++;
            if (m_idx[u] == NSYN - 1) begin m_st[u] = 2; m_drain[u] = L + 1; end
            else m_idx[u]++;
          end
        end
        default: begin
          m_drain[u]--;
          if (m_drain[u] == 0) begin m_st[u] = 0; nd = 1'b1; end
        end
      endcase
      m_done[u] = nd;
    end
    cyc++;
  endtask

  task automatic step(input bit st, input bit ln, input bit vl, input bit ab, input bit rn);
    @(posedge clk);
    #1;
    rst_n = rn; start = st; learn_en = ln; s_valid = vl; abort = ab;
    s_eps = 16'($urandom); s_mu = 16'($urandom);
    @(negedge clk);
    sample_and_step();
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #1;
    start = 1'b0; s_valid = 1'b1; abort = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) expect_reset_outputs(u);
    @(negedge clk);
    sample_and_step();
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
  endtask

  function automatic bit all_quiet();
    return (m_st[0] == 0) && (m_st[1] == 0) && !m_done[0] && !m_done[1];
  endfunction

  // mode: 0 full valid, 1 three-cycle stall after i=2, 2 abort after i=4, 3 random, 4 reset at i=5
  task automatic run_sweep(input int mode, input bit ln, input int exp_el, input int exp_len);
    int  guard;
    int  stall_left;
    bit  stalled, aborted, vl, ab, st, allowed;
    guard = 0; stall_left = 0; stalled = 1'b0; aborted = 1'b0;
    for (int u = 0; u < 2; u++) begin obs_el[u] = 0; first_x[u] = -1; done_at[u] = -1; end
    n_xfer = 0;
    step(0, ln, 1, 0, 1);
    step(1, ln, 1'($urandom), 0, 1);
    while (!all_quiet() && guard < 200) begin
      vl = 1'b1; ab = 1'b0;
      case (mode)
        1: begin
          if (n_xfer == 3 && !stalled) begin stalled = 1'b1; stall_left = 3; end
          if (stall_left > 0) begin vl = 1'b0; stall_left--; end
        end
        2: if (n_xfer == 5 && m_st[0] == 1 && !aborted) begin ab = 1'b1; aborted = 1'b1; end
        3: begin vl = ($urandom_range(0, 3) != 0); ab = ($urandom_range(0, 29) == 0); end
        4: if (n_xfer == 5 && m_st[0] == 1) begin reset_mid(); guard++; continue; end
        default: ;
      endcase
      allowed = (m_st[0] != 0 || m_done[0]) && (m_st[1] != 0 || m_done[1]);
      st = allowed && (m_st[0] == 2 || m_st[1] == 2 || $urandom_range(0, 3) == 0);
      step(st, 1'($urandom), vl, ab, 1);
      guard++;
    end
    expect_eq($sformatf("sweep_timeout_m%0d", mode), guard >= 200, 0);
    for (int u = 0; u < 2; u++) begin
      if (exp_el >= 0) expect_eq($sformatf("el_pulses%0d_m%0d", u, mode), obs_el[u], exp_el);
      if (exp_len > 0) expect_eq($sformatf("sweep_len%0d", u), done_at[u] - first_x[u], exp_len + lat(u));
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      m_st[u] = 0; m_idx[u] = 0; m_drain[u] = 0; m_lrn[u] = 0; m_done[u] = 0;
      m_ab[u] = 0; m_stall[u] = 0; m_upd[u] = 0;
    end
    repeat (3) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 1, 1, 1);
    run_sweep(0, 1, NSYN, NSYN + 1);
    run_sweep(1, 1, NSYN, 0);
    run_sweep(2, 1, 5, 0);
    run_sweep(0, 0, 0, NSYN + 1);
    run_sweep(4, 1, -1, 0);
    repeat (6) step(0, 1, 1'($urandom), 0, 1);
    run_sweep(0, 1, NSYN, NSYN + 1);
    for (int k = 0; k < 30; k++) run_sweep(3, 1'($urandom), -1, 0);
    run_sweep(0, 1, NSYN, NSYN + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
